fsk_symbol_sequencer: RTL and testbench
=======================================

// Module: fsk_symbol_sequencer
// PURPOSE
//  Upstream stage of the FSK tone generator. Accepts bytes over a valid/ready
//  handshake and frames each one UART-style: a start bit, 8 data bits LSB first,
//  then a stop bit. Each bit is a timed FSK symbol. Every sample clock the block
//  advances a phase index into the 64-entry waveform table by a per-symbol step
//  (mark/space/idle). It replaces button-driven tone selection with data-driven
//  keying; o6_mem_index drives the table read that feeds the DAC driver.
// PARAMETERS
//  BIT_SAMPLES  1000  sample clocks per symbol, >=2
//  STEP_MARK    10    index step for a '1' symbol (stop bit is mark)
//  STEP_SPACE   5     index step for a '0' symbol (start bit is space)
//  STEP_IDLE    1     index step while idle (carrier)
//  CNT_W        16    width of symbol sample counter, 2**CNT_W > BIT_SAMPLES
// PORTS
//  clk           in   1  sample clock (100 MHz domain, = DAC sample rate)
//  rst           in   1  synchronous reset, active-high
//  i8_data       in   8  byte to transmit
//  i_data_valid  in   1  i8_data valid
//  o_data_ready  out  1  block accepts i8_data this cycle
//  o6_mem_index  out  6  waveform table read index (registered)
//  o_busy        out  1  frame in progress (state != IDLE)
//  o_f_change    out  1  1 while the current symbol is mark (debug/LED)
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, sample counter=0, shift reg=0,
//    o6_mem_index=0, o_busy=0, o_f_change=0; o_data_ready=0 while rst=1.
//  - States: IDLE -> START -> DATA (bit counter 0..7) -> STOP -> IDLE or START.
//  - Symbol timing: the counter runs 0..BIT_SAMPLES-1 in START/DATA/STOP. At
//    the last count the state or bit advances and the counter returns to 0.
//    Every symbol lasts exactly BIT_SAMPLES cycles.
//  - Index update each edge (rst=0): o6_mem_index <= o6_mem_index + step. The
//    step comes from the state before that edge: IDLE=STEP_IDLE,
//    START=STEP_SPACE, DATA=shift[0]?STEP_MARK:STEP_SPACE, STOP=STEP_MARK.
//    The sum is modulo 64 (natural 6-bit wrap, no saturation).
//  - o_data_ready = !rst && (state==IDLE || (state==STOP && cnt==BIT_SAMPLES-1)).
//    This is combinational from state and counter, and does not depend on
//    i_data_valid.
//  - A transfer happens when valid && ready at an edge. The byte is loaded into
//    the shift reg, and the state becomes START with cnt=0 on that edge.
//    The first space step is applied at the following edge.
//  - On a transfer at the last STOP sample, START follows with no idle gap
//    (back-to-back frames). If there is no transfer, the state returns to IDLE.
//  - Valid outside the ready window is ignored. The byte is neither latched
//    nor dropped silently, because the upstream source holds it until ready.
//  - DATA: shift reg shifts right by 1 at each bit boundary. After bit 7 the
//    state goes to STOP.
//  - o_busy = (state!=IDLE). o_f_change = mark symbol active (DATA with
//    shift[0]=1, or STOP). Both are registered with the state.
//  - Reset mid-frame: the frame is abandoned immediately and all reset values
//    are applied. No partial stop bit is sent.
//  - Latency: byte accepted -> first space-step index change is 1 edge later.
//    A full frame is 10*BIT_SAMPLES cycles.
// TESTING
//  1 rst held 5 cycles then released, no valid -> index 0,1,2,...,63,0
//    (step 1, wraps); busy=0; ready=1.
//  2 BIT_SAMPLES=4, send 0xA5 from IDLE -> steps per symbol
//    5,10,5,10,5,5,10,5,10,10 (start, LSB-first data, stop), each for 4 cycles.
//    Index after the 40 frame cycles = start index + 300 mod 64 (= +44).
//    busy high for 40 cycles.
//  3 Valid held high with two bytes 0x00 then 0xFF -> ready pulses only at the
//    last STOP sample. Second START begins on the next cycle with no STEP_IDLE
//    cycle between the frames.
//  4 Valid pulsed mid-frame (DATA bit 3) with 0x3C -> ignored. Frame completes
//    with the original byte, and ready stays 0 until the STOP last sample.
//  5 rst asserted during DATA bit 5 -> next edge index=0, state IDLE, busy=0,
//    f_change=0. Stepping resumes at STEP_IDLE after release.
//  6 Send 0xFF -> o_f_change=1 from the first data sample through the stop bit,
//    and 0 during start and idle.

Source files
------------

// File: rtl/fsk_symbol_sequencer.sv
// Frames bytes UART-style (start, 8 data LSB first, stop) into timed FSK symbols
// and advances the waveform table read index by the per-symbol step every sample clock.
module fsk_symbol_sequencer #(
  parameter int BIT_SAMPLES = 1000,
  parameter int STEP_MARK   = 10,
  parameter int STEP_SPACE  = 5,
  parameter int STEP_IDLE   = 1,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i8_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [5:0] o6_mem_index,
  output logic       o_busy,
  output logic       o_f_change
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_SAMPLES - 1);
  localparam logic [5:0] INC_MARK  = 6'(STEP_MARK);
  localparam logic [5:0] INC_SPACE = 6'(STEP_SPACE);
  localparam logic [5:0] INC_IDLE  = 6'(STEP_IDLE);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [5:0]       step;
  logic             last, ready_win, xfer;

  assign last         = (cnt == CNT_LAST);
  assign ready_win    = (state == IDLE) || (state == STOP && last);
  assign o_data_ready = !rst && ready_win;
  assign xfer         = i_data_valid && o_data_ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    step      = INC_IDLE;
    case (state)
      IDLE: begin
        step = INC_IDLE;
        if (xfer) begin
          state_n = START;
          cnt_n   = '0;
          shift_n = i8_data;
        end
      end
      START: begin
        step = INC_SPACE;
        if (last) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        step = shift[0] ? INC_MARK : INC_SPACE;
        if (last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        step = INC_MARK;
        if (last) begin
          cnt_n = '0;
          // A byte offered on the final stop sample starts the next frame with no idle gap
          if (xfer) begin
            state_n = START;
            shift_n = i8_data;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      o6_mem_index <= '0;
      o_busy       <= 1'b0;
      o_f_change   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      o6_mem_index <= o6_mem_index + step;
      o_busy       <= (state_n != IDLE);
      o_f_change   <= (state_n == STOP) || (state_n == DATA && shift_n[0]);
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// Self-checking bench for fsk_symbol_sequencer: a frame-level model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_fsk_symbol_sequencer;

  localparam int BS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [5:0] idx;
  logic       busy;
  logic       fchg;

  int tests_run    = 0;
  int tests_failed = 0;
  bit checking     = 1'b0;

  fsk_symbol_sequencer #(
    .BIT_SAMPLES(BS),
    .STEP_MARK(10),
    .STEP_SPACE(5),
    .STEP_IDLE(1),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i8_data(data),
    .i_data_valid(valid),
    .o_data_ready(ready),
    .o6_mem_index(idx),
    .o_busy(busy),
    .o_f_change(fchg)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a frame is a 10-entry bit list (start=0, data LSB first, stop=1); each entry lasts BS cycles
  logic [9:0] m_frame = '0;
  bit         m_idle  = 1'b1;
  int         m_sym   = 0;
  int         m_smp   = 0;
  int         m_idx   = 0;

  function automatic bit modelReady();
    return !rst && (m_idle || (m_sym == 9 && m_smp == BS - 1));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1;
      m_sym  = 0;
      m_smp  = 0;
      m_idx  = 0;
    end else begin
      automatic bit xfer = valid && modelReady();
      automatic int step = m_idle ? 1 : (m_frame[m_sym] ? 10 : 5);
      m_idx = (m_idx + step) % 64;
      if (m_idle) begin
        if (xfer) begin
          m_frame = {1'b1, data, 1'b0};
          m_idle  = 1'b0;
          m_sym   = 0;
          m_smp   = 0;
        end
      end else if (m_smp == BS - 1) begin
        m_smp = 0;
        if (m_sym == 9) begin
          if (xfer) begin
            m_frame = {1'b1, data, 1'b0};
            m_sym   = 0;
          end else begin
            m_idle = 1'b1;
          end
        end else begin
          m_sym++;
        end
      end else begin
        m_smp++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_index", int'(idx), m_idx);
      checkOutput("model_busy", int'(busy), int'(!m_idle));
      checkOutput("model_fchange", int'(fchg), int'(!m_idle && m_frame[m_sym]));
      checkOutput("model_ready", int'(ready), int'(modelReady()));
    end
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one byte while idle; returns just after the accepting edge
  task automatic applyStimulus(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    waitEdges(1);
    valid = 1'b0;
  endtask

  int steps_a5 [10] = '{5, 10, 5, 10, 5, 5, 10, 5, 10, 10};
  int start_idx, prev, cnt_hi, pos;

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    waitEdges(5);
    checkOutput("reset_index", int'(idx), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_fchange", int'(fchg), 0);
    checkOutput("reset_ready", int'(ready), 0);
    checking = 1'b1;
    rst = 1'b0;
    #1;

    // Idle carrier: step 1 with natural 6-bit wrap
    for (int k = 0; k <= 64; k++) begin
      checkOutput("idle_index", int'(idx), k % 64);
      if (k == 0) begin
        checkOutput("idle_ready", int'(ready), 1);
        checkOutput("idle_busy", int'(busy), 0);
      end
      waitEdges(1);
    end

    // 0xA5 frame: per-symbol steps and total advance of 300 mod 64
    applyStimulus(8'hA5);
    start_idx = int'(idx);
    prev      = start_idx;
    cnt_hi    = 0;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < BS; c++) begin
        if (busy) cnt_hi++;
        waitEdges(1);
        checkOutput("a5_step", (int'(idx) - prev + 64) % 64, steps_a5[s]);
        prev = int'(idx);
      end
    end
    checkOutput("a5_final_index", int'(idx), (start_idx + 44) % 64);
    checkOutput("a5_busy_cycles", cnt_hi, 40);
    checkOutput("a5_busy_after", int'(busy), 0);

    // Back-to-back frames with valid held high
    data  = 8'h00;
    valid = 1'b1;
    waitEdges(1);
    data   = 8'hFF;
    cnt_hi = 0;
    pos    = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin
        cnt_hi++;
        pos = k;
      end
    end
    waitEdges(1);
    valid = 1'b0;
    checkOutput("b2b_ready_pulses", cnt_hi, 1);
    checkOutput("b2b_ready_position", pos, 40);
    checkOutput("b2b_busy_no_gap", int'(busy), 1);
    prev = int'(idx);
    waitEdges(1);
    checkOutput("b2b_first_space_step", (int'(idx) - prev + 64) % 64, 5);
    waitEdges(39);
    checkOutput("b2b_done_busy", int'(busy), 0);

    // Valid pulsed during DATA bit 3 is ignored
    applyStimulus(8'h81);
    start_idx = int'(idx);
    waitEdges(16);
    data   = 8'h3C;
    valid  = 1'b1;
    cnt_hi = 0;
    for (int j = 17; j <= 40; j++) begin
      @(negedge clk);
      if (ready) cnt_hi++;
      waitEdges(1);
      valid = 1'b0;
    end
    checkOutput("ignore_ready_count", cnt_hi, 1);
    checkOutput("ignore_final_index", int'(idx), (start_idx + 4) % 64);
    checkOutput("ignore_busy_after", int'(busy), 0);

    // Reset during DATA bit 5 abandons the frame
    applyStimulus(8'h55);
    waitEdges(25);
    rst = 1'b1;
    waitEdges(1);
    checkOutput("midrst_index", int'(idx), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_fchange", int'(fchg), 0);
    checkOutput("midrst_ready", int'(ready), 0);
    rst = 1'b0;
    waitEdges(1);
    checkOutput("midrst_resume1", int'(idx), 1);
    waitEdges(1);
    checkOutput("midrst_resume2", int'(idx), 2);

    // 0xFF: mark flag follows data and stop, clear during start and idle
    applyStimulus(8'hFF);
    for (int j = 0; j < 40; j++) begin
      checkOutput("ff_fchange", int'(fchg), (j >= BS) ? 1 : 0);
      waitEdges(1);
    end
    checkOutput("ff_fchange_idle", int'(fchg), 0);

    waitEdges(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
